// File: rtl/pio_pkg.sv
// Shared definitions for the PIO configuration loader: action codes, loader
// states and the field widths of the per-state-machine configuration words.
package pio_pkg;

  localparam int DIV_W   = 24;
  localparam int WRAP_W  = 5;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    ACT_NONE  = 4'd0,
    ACT_INSTR = 4'd1,
    ACT_PEND  = 4'd2,
    ACT_PULL  = 4'd3,
    ACT_PUSH  = 4'd4,
    ACT_GRPS  = 4'd5,
    ACT_EN    = 4'd6,
    ACT_DIV   = 4'd7,
    ACT_SIDES = 4'd8,
    ACT_IMM   = 4'd9,
    ACT_APUSH = 4'd10,
    ACT_APULL = 4'd11,
    ACT_IPINS = 4'd12,
    ACT_IDIRS = 4'd13,
    ACT_ISRT  = 4'd14,
    ACT_OSRT  = 4'd15
  } pio_action_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_INSTR  = 3'd2,
    ST_CFG    = 3'd3,
    ST_ENABLE = 3'd4,
    ST_FIN    = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/pio_next_sm.sv
// Priority finder: lowest set bit of the remaining mask at or above cur_idx,
// so the loader can hop straight to the next enabled state machine.
module pio_next_sm
  import pio_pkg::*;
#(
  parameter int NUM_SM = 4
) (
  input  logic [NUM_SM-1:0] rem_mask,
  input  logic [1:0]        cur_idx,
  output logic [1:0]        next_idx,
  output logic              none_left
);

  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    // Descending scan so the lowest qualifying index is the one that sticks.
    for (int n = NUM_SM - 1; n >= 0; n--) begin
      if (rem_mask[n] && (n >= int'(cur_idx))) begin
        next_idx  = 2'(n);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pio_cfg_loader.sv
// Sequencer that loads a program from instruction memory into the PIO and then
// configures and enables the selected state machines through the action port.
//
// state     | meaning
// ST_IDLE   | waiting for start; bad lengths pulse err and stay here
// ST_FETCH  | instruction reads still being issued (INSTR writes overlap)
// ST_INSTR  | reads done, draining the last fetched words as INSTR writes
// ST_CFG    | PEND / DIV / GRPS triple for the current state machine
// ST_ENABLE | EN action with the snapshot mask
// ST_FIN    | done pulse, back to idle next cycle
module pio_cfg_loader
  import pio_pkg::*;
#(
  parameter int NUM_SM     = 4,
  parameter int PROG_DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [5:0]               plen,
  input  logic [NUM_SM-1:0]        sm_mask,
  input  logic [NUM_SM*WRAP_W-1:0] wrap_end,
  input  logic [NUM_SM*DIV_W-1:0]  div,
  input  logic [NUM_SM*32-1:0]     pin_grps,
  output logic                     prog_rd,
  output logic [4:0]               prog_addr,
  input  logic [INSTR_W-1:0]       prog_data,
  output logic [3:0]               action,
  output logic [4:0]               index,
  output logic [1:0]               mindex,
  output logic [31:0]              din,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [5:0] MAX_LEN = 6'(PROG_DEPTH);

  ldr_state_e state_q, state_d;
  logic [5:0] plen_q;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic [5:0] iss_cnt_q, iss_cnt_d;
  logic [NUM_SM-1:0] mask_q, rem_q, rem_d;
  logic [1:0] sm_q, sm_d;
  logic [1:0] step_q, step_d;
  logic       rd_dly_q;
  logic       snap, advance;

  logic [WRAP_W-1:0] wrap_q [NUM_SM];
  logic [DIV_W-1:0]  div_q  [NUM_SM];
  logic [31:0]       grps_q [NUM_SM];

  logic              rd_n;
  logic [4:0]        addr_n;
  pio_action_e       act_n;
  logic [4:0]        idx_n;
  logic [1:0]        midx_n;
  logic [31:0]       din_n;
  logic              err_n;

  logic [1:0] nxt_sm;
  logic       none_left;

  pio_next_sm #(.NUM_SM(NUM_SM)) u_next_sm (
    .rem_mask  (rem_q),
    .cur_idx   (sm_q),
    .next_idx  (nxt_sm),
    .none_left (none_left)
  );

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    iss_cnt_d = iss_cnt_q;
    rem_d     = rem_q;
    sm_d      = sm_q;
    step_d    = step_q;
    snap      = 1'b0;
    advance   = 1'b0;
    rd_n      = 1'b0;
    addr_n    = '0;
    act_n     = ACT_NONE;
    idx_n     = '0;
    midx_n    = '0;
    din_n     = '0;
    err_n     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((plen == 6'd0) || (plen > MAX_LEN)) begin
            err_n = 1'b1;
          end else begin
            snap      = 1'b1;
            rd_n      = 1'b1;
            rd_cnt_d  = 6'd1;
            iss_cnt_d = '0;
            rem_d     = sm_mask;
            sm_d      = '0;
            step_d    = '0;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FETCH, ST_INSTR: begin
        if (iss_cnt_q == plen_q) begin
          advance = 1'b1;
        end else begin
          if (rd_cnt_q < plen_q) begin
            rd_n     = 1'b1;
            addr_n   = rd_cnt_q[4:0];
            rd_cnt_d = rd_cnt_q + 6'd1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_INSTR;
          end
          // Word fetched last cycle is on prog_data now.
          if (rd_dly_q) begin
            act_n     = ACT_INSTR;
            idx_n     = iss_cnt_q[4:0];
            din_n     = {{(32-INSTR_W){1'b0}}, prog_data};
            iss_cnt_d = iss_cnt_q + 6'd1;
          end
        end
      end
      ST_CFG: begin
        case (step_q)
          2'd0: begin
            act_n  = ACT_DIV;
            midx_n = sm_q;
            din_n  = 32'(div_q[sm_q]);
            step_d = 2'd1;
          end
          2'd1: begin
            act_n        = ACT_GRPS;
            midx_n       = sm_q;
            din_n        = grps_q[sm_q];
            step_d       = 2'd2;
            rem_d[sm_q]  = 1'b0;
          end
          default: advance = 1'b1;
        endcase
      end
      ST_ENABLE: state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (none_left) begin
        act_n   = ACT_EN;
        din_n   = 32'(mask_q);
        state_d = ST_ENABLE;
      end else begin
        act_n   = ACT_PEND;
        midx_n  = nxt_sm;
        din_n   = 32'(wrap_q[nxt_sm]);
        sm_d    = nxt_sm;
        step_d  = 2'd0;
        state_d = ST_CFG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      iss_cnt_q <= '0;
      rem_q     <= '0;
      sm_q      <= '0;
      step_q    <= '0;
      rd_dly_q  <= 1'b0;
      prog_rd   <= 1'b0;
      prog_addr <= '0;
      action    <= '0;
      index     <= '0;
      mindex    <= '0;
      din       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      rem_q     <= rem_d;
      sm_q      <= sm_d;
      step_q    <= step_d;
      rd_dly_q  <= prog_rd;
      prog_rd   <= rd_n;
      prog_addr <= addr_n;
      action    <= act_n;
      index     <= idx_n;
      mindex    <= midx_n;
      din       <= din_n;
      busy      <= (state_d != ST_IDLE) && (state_d != ST_FIN);
      done      <= (state_d == ST_FIN);
      err       <= err_n;
    end
  end

  // Snapshot is only read while a load is running, so it needs no reset.
  always_ff @(posedge clk) begin
    if (snap) begin
      plen_q <= plen;
      mask_q <= sm_mask;
      for (int n = 0; n < NUM_SM; n++) begin
        wrap_q[n] <= wrap_end[WRAP_W*n +: WRAP_W];
        div_q[n]  <= div[DIV_W*n +: DIV_W];
        grps_q[n] <= pin_grps[32*n +: 32];
      end
    end
  end

endmodule

// File: tb/tb_pio_cfg_loader.sv
// Scoreboard bench for pio_cfg_loader: loads push expected events with their
// cycle numbers, an independent monitor pops and compares what the DUT shows.
module tb_pio_cfg_loader;
  import pio_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   plen = '0;
  logic [3:0]   sm_mask = '0;
  logic [19:0]  wrap_end = '0;
  logic [95:0]  div = '0;
  logic [127:0] pin_grps = '0;
  logic         prog_rd;
  logic [4:0]   prog_addr;
  logic [15:0]  prog_data = '0;
  logic [3:0]   action;
  logic [4:0]   index;
  logic [1:0]   mindex;
  logic [31:0]  din;
  logic         busy, done, err;

  pio_cfg_loader #(.NUM_SM(4), .PROG_DEPTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .plen(plen), .sm_mask(sm_mask),
    .wrap_end(wrap_end), .div(div), .pin_grps(pin_grps),
    .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
    .action(action), .index(index), .mindex(mindex), .din(din),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [1:0]  midx;
    logic [31:0] din;
  } ev_t;

  ev_t act_q[$], rd_q[$], done_q[$], err_q[$];
  ev_t mon_e, mon_a;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int c0 = 0;
  bit mon_en = 1'b0;

  logic [15:0] mem [32];
  logic [4:0]  m_wrap [4];
  logic [23:0] m_div  [4];
  logic [31:0] m_grps [4];
  logic        mem_rd;
  logic [4:0]  mem_a;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pk(input ev_t e);
    return {5'd0, e.cyc[15:0], e.act, e.idx, e.midx, e.din};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h expected no event (cycle %0d)", nm, got, cyc);
  endtask

  // Instruction memory: a word read in one cycle appears on prog_data in the next.
  initial forever begin
    @(negedge clk);
    mem_rd = prog_rd;
    mem_a  = prog_addr;
    @(posedge clk);
    #1;
    prog_data = mem_rd ? mem[mem_a] : 16'($urandom);
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (action != 4'd0) begin
        mon_a = '{cyc, action, index, mindex, din};
        if (act_q.size() == 0) unexp("action_unexpected", pk(mon_a));
        else begin
          mon_e = act_q.pop_front();
          chk("action_event", pk(mon_a), pk(mon_e));
        end
      end else begin
        chk("idle_fields", 64'({index, mindex, din}), 64'd0);
      end
      if (prog_rd) begin
        mon_a = '{cyc, 4'd0, prog_addr, 2'd0, 32'd0};
        if (rd_q.size() == 0) unexp("read_unexpected", pk(mon_a));
        else begin
          mon_e = rd_q.pop_front();
          chk("read_event", pk(mon_a), pk(mon_e));
        end
      end
      if (done) begin
        mon_a = '{cyc, 4'd0, 5'd0, 2'd0, 32'd0};
        if (done_q.size() == 0) unexp("done_unexpected", pk(mon_a));
        else begin
          mon_e = done_q.pop_front();
          chk("done_cycle", pk(mon_a), pk(mon_e));
        end
      end
      if (err) begin
        mon_a = '{cyc, 4'd0, 5'd0, 2'd0, 32'd0};
        if (err_q.size() == 0) unexp("err_unexpected", pk(mon_a));
        else begin
          mon_e = err_q.pop_front();
          chk("err_cycle", pk(mon_a), pk(mon_e));
        end
      end
    end
  end

  task automatic rnd_cfg();
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 4; n++) begin
      m_wrap[n] = 5'($urandom);
      m_div[n]  = 24'($urandom);
      m_grps[n] = $urandom;
    end
  endtask

  task automatic drive_cfg();
    for (int n = 0; n < 4; n++) begin
      wrap_end[5*n +: 5]  = m_wrap[n];
      div[24*n +: 24]     = m_div[n];
      pin_grps[32*n +: 32] = m_grps[n];
    end
  endtask

  task automatic run_load(input int pl, input logic [3:0] mask, input bit fuzz);
    int t, k, total;
    bit ok_len;
    ok_len = (pl >= 1) && (pl <= 32);
    @(negedge clk);
    plen    = 6'(pl);
    sm_mask = mask;
    drive_cfg();
    start    = 1'b1;
    c0       = cyc;
    busy_cnt = 0;
    if (!ok_len) begin
      err_q.push_back('{c0 + 1, 4'd0, 5'd0, 2'd0, 32'd0});
      total = 3;
    end else begin
      for (int i = 0; i < pl; i++) begin
        rd_q.push_back('{c0 + 1 + i, 4'd0, 5'(i), 2'd0, 32'd0});
        act_q.push_back('{c0 + 3 + i, 4'd1, 5'(i), 2'd0, {16'd0, mem[i]}});
      end
      t = c0 + 3 + pl;
      k = 0;
      for (int n = 0; n < 4; n++) begin
        if (mask[n]) begin
          act_q.push_back('{t,     4'd2, 5'd0, 2'(n), {27'd0, m_wrap[n]}});
          act_q.push_back('{t + 1, 4'd7, 5'd0, 2'(n), {8'd0, m_div[n]}});
          act_q.push_back('{t + 2, 4'd5, 5'd0, 2'(n), m_grps[n]});
          t += 3;
          k++;
        end
      end
      act_q.push_back('{t, 4'd6, 5'd0, 2'd0, {28'd0, mask}});
      done_q.push_back('{t + 1, 4'd0, 5'd0, 2'd0, 32'd0});
      total = 4 + pl + 3 * k;
    end
    for (int m = 1; m <= total + 2; m++) begin
      @(negedge clk);
      start = 1'b0;
      if (fuzz && ok_len) begin
        plen     = 6'($urandom);
        sm_mask  = 4'($urandom);
        wrap_end = 20'($urandom);
        div      = {$urandom, $urandom, $urandom};
        pin_grps = {$urandom, $urandom, $urandom, $urandom};
        if (m <= total - 1 && $urandom_range(3) == 0) start = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("busy_cycles", 64'(busy_cnt), ok_len ? 64'(total - 1) : 64'd0);
    chk("events_drained", 64'(act_q.size() + rd_q.size() + done_q.size() + err_q.size()), 64'd0);
  endtask

  task automatic run_reset_mid();
    rnd_cfg();
    @(negedge clk);
    plen    = 6'd8;
    sm_mask = 4'b0111;
    drive_cfg();
    start = 1'b1;
    c0    = cyc;
    for (int i = 0; i <= 4; i++) rd_q.push_back('{c0 + 1 + i, 4'd0, 5'(i), 2'd0, 32'd0});
    for (int i = 0; i <= 2; i++) act_q.push_back('{c0 + 3 + i, 4'd1, 5'(i), 2'd0, {16'd0, mem[i]}});
    for (int m = 1; m <= 5; m++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs",
        64'({prog_rd, prog_addr, action, index, mindex, din, busy, done, err}), 64'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    @(posedge clk);
    #1;
    chk("reset_mid_drained", 64'(act_q.size() + rd_q.size() + done_q.size() + err_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rnd_cfg();
    repeat (3) @(negedge clk);
    chk("reset_state",
        64'({prog_rd, prog_addr, action, index, mindex, din, busy, done, err}), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Basic two-word load
    rnd_cfg();
    mem[0] = 16'hE001; mem[1] = 16'h0000;
    m_wrap[0] = 5'd1; m_div[0] = 24'h000280; m_grps[0] = 32'h0400_0000;
    run_load(2, 4'b0001, 1'b0);

    rnd_cfg();
    run_load(1, 4'b1010, 1'b0);

    run_load(0, 4'b1111, 1'b0);
    run_load(33, 4'b0001, 1'b0);

    rnd_cfg();
    run_load(32, 4'b1111, 1'b0);

    rnd_cfg();
    run_load(5, 4'b0000, 1'b1);

    run_reset_mid();

    repeat (30) begin
      rnd_cfg();
      run_load(int'($urandom_range(0, 36)), 4'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_cfg_loader.md
Name: pio_cfg_loader

Overview:
- Hardware sequencer that configures the PIO block through its action/din/index/mindex port, replacing bench-driven configuration.
- On `start`, streams a program from an external instruction memory into the PIO.
- For every state machine enabled in a mask, it then writes wrap end, clock divider and pin groups.
- It finishes with a single EN action carrying the enable mask.
- Sits between the system/boot logic and `pio`; generalised over state-machine count and program depth.

Parameters:
- NUM_SM, 4, number of PIO state machines (1..4; sets mindex range).
- PROG_DEPTH, 32, instruction memory depth (≤32; sets the index range).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; honoured only in IDLE.
- plen  in  6  program length in words.
- sm_mask  in  NUM_SM  state machines to configure and enable.
- wrap_end  in  NUM_SM*5  per-SM wrap end (PEND value); SM n at bits [5n+4:5n].
- div  in  NUM_SM*24  per-SM fractional divider; SM n at bits [24n+23:24n].
- pin_grps  in  NUM_SM*32  per-SM pin-group word; SM n at bits [32n+31:32n].
- prog_rd  out  1  instruction memory read strobe.
- prog_addr  out  5  instruction memory address.
- prog_data  in  16  instruction word; valid the cycle after prog_rd.
- action  out  4  PIO action code.
- index  out  5  instruction slot for INSTR actions.
- mindex  out  2  state-machine select.
- din  out  32  action data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse when `start` is rejected.

Behaviour:
- **Registered outputs.** All outputs are registered. Reset value of every output is 0; action 0 = NONE.
- **Reset mid-load.** Reset during a load aborts it: the next edge gives IDLE, all outputs 0, and no done pulse.
- **Start acceptance.** `start` sampled in IDLE (cycle C0) snapshots plen, sm_mask, wrap_end, div and pin_grps. Later input changes do not affect the load.
- **Start rejection.** If plen==0 or plen>PROG_DEPTH: err=1 in C1 and the block stays IDLE; no actions or reads are issued.
- **`start` while busy** is ignored (no err).
- **States:** IDLE → FETCH → INSTR → CFG → ENABLE → FIN → IDLE.
- **FETCH / INSTR:**
  - prog_rd=1 with prog_addr=i in cycle C1+i, for i = 0..plen-1.
  - In cycle C3+i: action=INSTR(1), index=i, din={16'b0, prog_data word i}, mindex=0.
  - Reads are pipelined, so one INSTR is issued per cycle with no bubbles.
- **CFG:**
  - Enabled state machines are visited in ascending order; disabled ones cost zero cycles.
  - Each visited SM n gets three consecutive cycles, all with mindex=n and index=0:
    - PEND(2), din = zero-extended wrap_end[n].
    - DIV(7), din = zero-extended div[n].
    - GRPS(5), din = pin_grps[n].
  - The first PEND is in cycle C3+plen.
- **ENABLE:** with k = popcount(sm_mask), cycle C3+plen+3k issues action=EN(6), mindex=0, din = zero-extended sm_mask. This cycle is issued even when sm_mask==0, so the PIO is explicitly disabled.
- **FIN:** in cycle C4+plen+3k: action=NONE, din=0, done=1, busy=0. The next cycle is IDLE.
- **busy** is 1 from C1 through C3+plen+3k inclusive.
- **Outside issue cycles:** action=NONE, din=0, index=0, mindex=0.
- **Total load time:** 4+plen+3k cycles from start to done.
- **Maximum load:** plen=32, k=4 gives 48 cycles. The internal 6-bit word counter must not wrap at plen=32.

Decomposition:
- Package `pio_pkg` holds:
  - action codes NONE=0, INSTR=1, PEND=2, PULL=3, PUSH=4, GRPS=5, EN=6, DIV=7, SIDES=8, IMM=9, APUSH=10, APULL=11, IPINS=12, IDIRS=13, ISRT=14, OSRT=15;
  - the loader state enum;
  - field widths DIV_W=24, WRAP_W=5, INSTR_W=16.
- Sub-module `pio_next_sm`: combinational priority finder.
  - Inputs: remaining-mask and current index.
  - Outputs: next enabled SM index and a `none_left` flag.
  - Used to step CFG without idle cycles.

Test Plan:
- **Basic two-word load.** plen=2, prog={E001,0000}, mask=0001, wrap_end[0]=1, div[0]=0x000280, pin_grps[0]=0x04000000:
  - C3 INSTR idx0 din=E001; C4 INSTR idx1 din=0;
  - C5 PEND din=1; C6 DIV din=0x280; C7 GRPS din=0x04000000;
  - C8 EN din=1; C9 done=1.
- **Sparse mask.** mask=1010, plen=1 → CFG visits mindex=1 then mindex=3 (6 cycles); EN din=0xA; done in C11.
- **Rejected lengths.** plen=0 and plen=33 → err pulse in C1, action stays NONE, busy never rises.
- **Maximum load.** plen=32, mask=1111 → 32 back-to-back INSTR with index 0..31; done in C48; busy high for exactly 47 cycles.
- **Reset and snapshot.** Reset asserted at C5 of a plen=8 load → outputs all 0 from C6 and no done pulse. Separately, changing div and mask inputs mid-load leaves the snapshot values on din.
- **Busy start and empty mask.** `start` re-asserted while busy is ignored. A load with mask=0 issues EN din=0 in cycle C3+plen.
